// File: rtl/dec_router_param_pkg.sv
// dec_param_pkg: flit field positions, port indices and helpers for dec_router_param
package dec_param_pkg;
  localparam int N = 0;
  localparam int E = 1;
  localparam int S = 2;
  localparam int W = 3;
  localparam int LOCAL = 4;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int POS_VALID(input int age_w, input int coord_w, input int payload_w);
    return age_w + 2 * coord_w + payload_w;
  endfunction
  function automatic int POS_AGE(input int coord_w, input int payload_w);
    return 2 * coord_w + payload_w;
  endfunction
  function automatic int POS_DST_X(input int coord_w, input int payload_w);
    return coord_w + payload_w;
  endfunction
  function automatic int POS_DST_Y(input int payload_w);
    return payload_w;
  endfunction
endpackage

// File: rtl/dec_router_param_inj_fifo.sv
// inj_fifo: ready/valid injection FIFO with synchronous reset and occupancy count
module inj_fifo import dec_param_pkg::*; #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic          ready,
  output logic          empty,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign ready = count != CW'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rp];
  assign do_push = push && ready;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/dec_router_param.sv
// dec_router_param: bufferless XY deflection router with oldest-first allocation, injection FIFO and ejection
module dec_router_param import dec_param_pkg::*; #(
  parameter int CORD_X = 0,
  parameter int CORD_Y = 0,
  parameter int COORD_W = 2,
  parameter int AGE_W = 4,
  parameter int PAYLOAD_W = 32,
  parameter int INJ_DEPTH = 4,
  parameter int STAT_W = 16,
  localparam int FLIT_W = 1 + AGE_W + 2 * COORD_W + PAYLOAD_W,
  localparam int CNT_W = clog2(INJ_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] din_n,
  input  logic [FLIT_W-1:0] din_e,
  input  logic [FLIT_W-1:0] din_s,
  input  logic [FLIT_W-1:0] din_w,
  output logic [FLIT_W-1:0] dout_n,
  output logic [FLIT_W-1:0] dout_e,
  output logic [FLIT_W-1:0] dout_s,
  output logic [FLIT_W-1:0] dout_w,
  input  logic              inj_valid,
  input  logic [FLIT_W-1:0] inj_flit,
  output logic              inj_ready,
  output logic [FLIT_W-1:0] dout_local,
  output logic [CNT_W-1:0]  inj_count,
  output logic [STAT_W-1:0] deflect_cnt
);
  localparam int PV = POS_VALID(AGE_W, COORD_W, PAYLOAD_W);
  localparam int PA = POS_AGE(COORD_W, PAYLOAD_W);
  localparam int PX = POS_DST_X(COORD_W, PAYLOAD_W);
  localparam int PY = POS_DST_Y(PAYLOAD_W);
  function automatic logic [AGE_W-1:0] age(input logic [FLIT_W-1:0] f);
    return f[PA +: AGE_W];
  endfunction
  function automatic logic is_local(input logic [FLIT_W-1:0] f);
    return f[PV] && f[PX +: COORD_W] == COORD_W'(CORD_X) && f[PY +: COORD_W] == COORD_W'(CORD_Y);
  endfunction
  function automatic logic [2:0] prod_x(input logic [FLIT_W-1:0] f);
    return f[PX +: COORD_W] > COORD_W'(CORD_X) ? 3'(E) : f[PX +: COORD_W] < COORD_W'(CORD_X) ? 3'(W) : 3'(LOCAL);
  endfunction
  function automatic logic [2:0] prod_y(input logic [FLIT_W-1:0] f);
    return f[PY +: COORD_W] > COORD_W'(CORD_Y) ? 3'(N) : f[PY +: COORD_W] < COORD_W'(CORD_Y) ? 3'(S) : 3'(LOCAL);
  endfunction
  function automatic logic [FLIT_W-1:0] fwd(input logic [FLIT_W-1:0] f);
    return {1'b1, &age(f) ? age(f) : age(f) + AGE_W'(1), f[PA-1:0]};
  endfunction
  logic [FLIT_W-1:0] s1 [4];
  logic [FLIT_W-1:0] s3 [4];
  logic [FLIT_W-1:0] slot [4];
  logic [FLIT_W-1:0] nxt [4];
  logic [FLIT_W-1:0] loc_d, loc_q;
  logic [PA-1:0] head;
  logic [1:0] rank [4];
  logic [1:0] ej_idx, ff, p;
  logic [2:0] px, py, ndefl;
  logic [3:0] busy;
  logic ej_hit, free, pop, empty, inj_done, ok_x, ok_y;
  logic [STAT_W:0] sum;
  logic unused;
  assign unused = ^inj_flit[FLIT_W-1:PA];
  inj_fifo #(.W(PA), .DEPTH(INJ_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(inj_valid), .din(inj_flit[PA-1:0]), .pop(pop),
    .ready(inj_ready), .empty(empty), .head(head), .count(inj_count)
  );
  always_comb begin
    slot = s1;
    ej_hit = 1'b0;
    ej_idx = '0;
    for (int i = 0; i < 4; i++)
      if (is_local(s1[i]) && (!ej_hit || age(s1[i]) > age(s1[ej_idx]))) begin
        ej_hit = 1'b1;
        ej_idx = 2'(i);
      end
    if (ej_hit) slot[ej_idx] = '0;
    free = 1'b0;
    for (int i = 0; i < 4; i++) if (!slot[i][PV]) free = 1'b1;
    pop = !empty && free && (!is_local({1'b1, {AGE_W{1'b0}}, head}) || !ej_hit);
    loc_d = ej_hit ? s1[ej_idx] : '0;
    inj_done = 1'b0;
    if (pop && is_local({1'b1, {AGE_W{1'b0}}, head})) loc_d = {1'b1, {AGE_W{1'b0}}, head};
    else if (pop)
      for (int i = 0; i < 4; i++)
        if (!inj_done && !slot[i][PV]) begin
          slot[i] = {1'b1, {AGE_W{1'b0}}, head};
          inj_done = 1'b1;
        end
    for (int i = 0; i < 4; i++) begin
      rank[i] = '0;
      for (int j = 0; j < 4; j++)
        if (j != i && slot[j][PV] && (age(slot[j]) > age(slot[i]) || (age(slot[j]) == age(slot[i]) && j < i)))
          rank[i] = rank[i] + 2'd1;
    end
    nxt = '{default: '0};
    busy = '0;
    ndefl = '0;
    px = '0;
    py = '0;
    ff = '0;
    p = '0;
    ok_x = 1'b0;
    ok_y = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++)
        if (slot[i][PV] && rank[i] == 2'(r)) begin
          px = prod_x(slot[i]);
          py = prod_y(slot[i]);
          ok_x = !px[2] && !busy[px[1:0]];
          ok_y = !py[2] && !busy[py[1:0]];
          ff = '0;
          for (int k = 3; k >= 0; k--) if (!busy[k]) ff = 2'(k);
          p = ok_x ? px[1:0] : ok_y ? py[1:0] : ff;
          ndefl = ndefl + 3'(!ok_x && !ok_y);
          busy[p] = 1'b1;
          nxt[p] = fwd(slot[i]);
        end
  end
  assign sum = {1'b0, deflect_cnt} + (STAT_W + 1)'(ndefl);
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '{default: '0};
      s3 <= '{default: '0};
      loc_q <= '0;
      deflect_cnt <= '0;
    end else begin
      s1 <= '{din_n, din_e, din_s, din_w};
      s3 <= nxt;
      loc_q <= loc_d;
      deflect_cnt <= sum[STAT_W] ? '1 : sum[STAT_W-1:0];
    end
  end
  assign dout_n = s3[N];
  assign dout_e = s3[E];
  assign dout_s = s3[S];
  assign dout_w = s3[W];
  assign dout_local = loc_q;
endmodule

// File: tb/tb_dec_router_param.sv
// tb_dec_router_param: scoreboard bench for dec_router_param at node (1,1)
module tb_dec_router_param;
  typedef struct {
    int due;
    logic [40:0] n, e, s, w, l;
    logic [15:0] d;
  } exp_t;
  logic clk, reset, inj_valid, inj_ready;
  logic [40:0] din_n, din_e, din_s, din_w, dout_n, dout_e, dout_s, dout_w, inj_flit, dout_local;
  logic [2:0] inj_count;
  logic [15:0] deflect_cnt;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t q[$];
  exp_t it;
  dec_router_param #(.CORD_X(1), .CORD_Y(1)) dut (
    .clk(clk), .reset(reset), .din_n(din_n), .din_e(din_e), .din_s(din_s), .din_w(din_w),
    .dout_n(dout_n), .dout_e(dout_e), .dout_s(dout_s), .dout_w(dout_w),
    .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_ready(inj_ready),
    .dout_local(dout_local), .inj_count(inj_count), .deflect_cnt(deflect_cnt)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk)
    while (q.size() > 0 && q[0].due <= cyc) begin
      it = q.pop_front();
      check("dout_n", 64'(dout_n), 64'(it.n));
      check("dout_e", 64'(dout_e), 64'(it.e));
      check("dout_s", 64'(dout_s), 64'(it.s));
      check("dout_w", 64'(dout_w), 64'(it.w));
      check("dout_local", 64'(dout_local), 64'(it.l));
      check("deflect_cnt", 64'(deflect_cnt), 64'(it.d));
    end
  function automatic logic [40:0] mk(input logic v, input logic [3:0] a, input logic [1:0] x, input logic [1:0] y,
                                     input logic [31:0] pl);
    return {v, a, x, y, pl};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [40:0] n, e, s, w, xn, xe, xs, xw, xl, input logic [15:0] d);
    exp_t x;
    din_n = n;
    din_e = e;
    din_s = s;
    din_w = w;
    x.due = cyc + 2;
    x.n = xn;
    x.e = xe;
    x.s = xs;
    x.w = xw;
    x.l = xl;
    x.d = d;
    q.push_back(x);
  endtask
  task automatic idle(input int k, input logic [15:0] d);
    repeat (k) begin
      drive('0, '0, '0, '0, '0, '0, '0, '0, '0, d);
      tick();
    end
  endtask
  task automatic reset_dut();
    for (int k = 0; k < 8 && q.size() > 0; k++) idle(1, deflect_cnt);
    for (int k = 0; k < 4 && q.size() > 0; k++) tick();
    reset = 1;
    tick();
    reset = 0;
  endtask
  logic [40:0] an, ae, as_, aw, an1, ae1, as1, aw1, pn, pe, ps, pw;
  initial begin
    reset = 1;
    inj_valid = 0;
    inj_flit = '0;
    din_n = '0;
    din_e = '0;
    din_s = '0;
    din_w = '0;
    repeat (2) tick();
    check("rst_dout_n", 64'(dout_n), 0);
    check("rst_dout_e", 64'(dout_e), 0);
    check("rst_dout_local", 64'(dout_local), 0);
    check("rst_inj_count", 64'(inj_count), 0);
    check("rst_inj_ready", 64'(inj_ready), 1);
    check("rst_deflect", 64'(deflect_cnt), 0);
    reset = 0;
    drive('0, mk(1, 2, 3, 1, 32'hA1), '0, '0, '0, mk(1, 3, 3, 1, 32'hA1), '0, '0, '0, 0);
    tick();
    drive(mk(1, 15, 1, 3, 32'hB2), '0, '0, '0, mk(1, 15, 1, 3, 32'hB2), '0, '0, '0, '0, 0);
    tick();
    idle(2, 0);
    drive(mk(1, 5, 2, 1, 32'hC3), '0, mk(1, 5, 2, 1, 32'hD4), '0,
          mk(1, 6, 2, 1, 32'hD4), mk(1, 6, 2, 1, 32'hC3), '0, '0, '0, 1);
    tick();
    idle(2, 1);
    drive('0, mk(1, 7, 1, 1, 32'hE5), '0, mk(1, 3, 1, 1, 32'hF6),
          mk(1, 4, 1, 1, 32'hF6), '0, '0, '0, mk(1, 7, 1, 1, 32'hE5), 2);
    tick();
    idle(2, 2);
    drive(mk(1, 2, 1, 1, 32'h10), mk(1, 6, 1, 1, 32'h11), mk(1, 6, 1, 1, 32'h12), mk(1, 1, 1, 1, 32'h13),
          mk(1, 7, 1, 1, 32'h12), mk(1, 3, 1, 1, 32'h10), mk(1, 2, 1, 1, 32'h13), '0, mk(1, 6, 1, 1, 32'h11), 5);
    tick();
    idle(2, 5);
    reset_dut();
    inj_valid = 1;
    inj_flit = mk(0, 5, 1, 1, 32'h77);
    drive('0, '0, '0, '0, '0, '0, '0, '0, mk(1, 0, 1, 1, 32'h77), 0);
    tick();
    inj_valid = 0;
    idle(3, 0);
    check("inj_local_count", 64'(inj_count), 0);
    an = mk(1, 0, 1, 3, 32'h21);
    ae = mk(1, 0, 3, 1, 32'h22);
    as_ = mk(1, 0, 1, 0, 32'h23);
    aw = mk(1, 0, 0, 1, 32'h24);
    an1 = mk(1, 1, 1, 3, 32'h21);
    ae1 = mk(1, 1, 3, 1, 32'h22);
    as1 = mk(1, 1, 1, 0, 32'h23);
    aw1 = mk(1, 1, 0, 1, 32'h24);
    reset_dut();
    inj_valid = 1;
    inj_flit = mk(0, 9, 3, 1, 32'h99);
    drive(an, ae, as_, aw, an1, ae1, as1, aw1, '0, 0);
    tick();
    inj_valid = 0;
    check("inj_count_push", 64'(inj_count), 1);
    drive(an, '0, as_, aw, an1, mk(1, 1, 3, 1, 32'h99), as1, aw1, '0, 0);
    tick();
    check("inj_count_full_net", 64'(inj_count), 1);
    idle(1, 0);
    check("inj_count_popped", 64'(inj_count), 0);
    idle(2, 0);
    reset_dut();
    drive(an, ae, as_, aw, an1, ae1, as1, aw1, '0, 0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      inj_valid = 1;
      inj_flit = mk(0, 0, 3, 1, 32'hF0 + k);
      drive(an, ae, as_, aw, an1, ae1, as1, aw1, '0, 0);
      tick();
    end
    check("fifo_count_full", 64'(inj_count), 4);
    check("fifo_ready_full", 64'(inj_ready), 0);
    inj_flit = mk(0, 0, 3, 1, 32'hF5);
    drive(an, ae, as_, aw, an1, ae1, as1, aw1, '0, 0);
    tick();
    inj_valid = 0;
    check("fifo_push_ignored", 64'(inj_count), 4);
    drive(an, '0, as_, aw, an1, mk(1, 1, 3, 1, 32'hF1), as1, aw1, '0, 0);
    tick();
    drive(an, '0, as_, aw, an1, mk(1, 1, 3, 1, 32'hF2), as1, aw1, '0, 0);
    tick();
    check("fifo_count_pop", 64'(inj_count), 3);
    check("fifo_ready_pop", 64'(inj_ready), 1);
    inj_valid = 1;
    inj_flit = mk(0, 0, 3, 1, 32'hF6);
    drive(an, ae, as_, aw, an1, ae1, as1, aw1, '0, 0);
    tick();
    inj_valid = 0;
    check("fifo_push_pop", 64'(inj_count), 3);
    drive('0, '0, '0, '0, '0, mk(1, 1, 3, 1, 32'hF3), '0, '0, '0, 0);
    tick();
    drive('0, '0, '0, '0, '0, mk(1, 1, 3, 1, 32'hF4), '0, '0, '0, 0);
    tick();
    drive('0, '0, '0, '0, '0, mk(1, 1, 3, 1, 32'hF6), '0, '0, '0, 0);
    tick();
    idle(2, 0);
    check("fifo_drained", 64'(inj_count), 0);
    pn = mk(1, 0, 3, 1, 32'h31);
    pe = mk(1, 0, 3, 1, 32'h32);
    ps = mk(1, 0, 3, 1, 32'h33);
    pw = mk(1, 0, 3, 1, 32'h34);
    reset_dut();
    for (int k = 1; k <= 3; k++) begin
      drive(pn, pe, ps, pw, mk(1, 1, 3, 1, 32'h32), mk(1, 1, 3, 1, 32'h31), mk(1, 1, 3, 1, 32'h33),
            mk(1, 1, 3, 1, 32'h34), '0, 16'(3 * k));
      tick();
    end
    repeat (22000) tick();
    check("deflect_saturated", 64'(deflect_cnt), 64'hFFFF);
    inj_valid = 1;
    inj_flit = mk(0, 0, 3, 1, 32'h55);
    reset = 1;
    tick();
    check("midrst_dout_n", 64'(dout_n), 0);
    check("midrst_dout_e", 64'(dout_e), 0);
    check("midrst_dout_s", 64'(dout_s), 0);
    check("midrst_dout_w", 64'(dout_w), 0);
    check("midrst_count", 64'(inj_count), 0);
    check("midrst_ready", 64'(inj_ready), 1);
    check("midrst_deflect", 64'(deflect_cnt), 0);
    reset = 0;
    inj_valid = 0;
    din_n = '0;
    din_e = '0;
    din_s = '0;
    din_w = '0;
    repeat (3) tick();
    check("sb_drained", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
